// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one subtract/compare step per cycle,
// signed operands handled as magnitudes with a final sign-fix cycle.
// Divide-by-zero and signed MIN/-1 bypass the iteration entirely.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             Ovfl
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Iteration state: partial remainder, shifting dividend/quotient, divisor magnitude
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CW-1:0]    count_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;

    // Visible results, only touched on accept, in FIX, or on reset
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;
    logic             ovfl_reg;

    // Operand decode at the start cycle
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             dvs_zero, signed_ovf;

    assign dvd_neg    = signed_op & dividend[WIDTH-1];
    assign dvs_neg    = signed_op & divisor[WIDTH-1];
    // Negating MIN yields MIN, which read as unsigned is exactly its magnitude
    assign dvd_mag    = dvd_neg ? -dividend : dividend;
    assign dvs_mag    = dvs_neg ? -divisor : divisor;
    assign dvs_zero   = (divisor == '0);
    assign signed_ovf = signed_op && (dividend == MIN_VAL) && (divisor == '1);

    // One restoring step. The shifted remainder needs WIDTH+1 bits so that
    // unsigned divisors with the MSB set compare correctly; when the trial
    // succeeds the difference is below the divisor and fits in WIDTH bits.
    logic [WIDTH:0]   shifted;
    logic             trial_ok;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
    assign trial_ok = (shifted >= {1'b0, dvs_reg});
    assign diff     = shifted[WIDTH-1:0] - dvs_reg;
    assign rem_step = trial_ok ? diff : shifted[WIDTH-1:0];
    assign quo_step = {quo_reg[WIDTH-2:0], trial_ok};

    // Sign correction applied in FIX
    logic [WIDTH-1:0] q_fix, r_fix;
    assign q_fix = q_neg_reg ? -quo_reg : quo_reg;
    assign r_fix = r_neg_reg ? -rem_reg : rem_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (dvs_zero || signed_ovf) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (count_reg == LAST_STEP) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            count_reg     <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovfl_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        dbz_reg  <= 1'b0;
                        ovfl_reg <= 1'b0;
                        if (dvs_zero) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                        end else if (signed_ovf) begin
                            quotient_reg  <= MIN_VAL;
                            remainder_reg <= '0;
                            ovfl_reg      <= 1'b1;
                        end else begin
                            rem_reg   <= '0;
                            quo_reg   <= dvd_mag;
                            dvs_reg   <= dvs_mag;
                            count_reg <= '0;
                            q_neg_reg <= dvd_neg ^ dvs_neg;
                            r_neg_reg <= dvd_neg;
                        end
                    end
                end
                S_CALC: begin
                    rem_reg   <= rem_step;
                    quo_reg   <= quo_step;
                    count_reg <= count_reg + CW'(1);
                end
                S_FIX: begin
                    quotient_reg  <= q_fix;
                    remainder_reg <= r_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign Ovfl        = ovfl_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic model.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         ovfl;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] q_prev = '0;
    logic [W-1:0] r_prev = '0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .Ovfl        (ovfl)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SV / and % truncate toward zero
    // with the remainder taking the dividend's sign.
    task automatic ref_model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] q, output logic [W-1:0] r,
                             output bit dz, output bit ov, output int lat);
        longint sa, sb, qq, rr;
        dz = 0;
        ov = 0;
        if (b == 0) begin
            q = '1; r = a; dz = 1; lat = 1;
        end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000; r = '0; ov = 1; lat = 1;
        end else begin
            lat = W + 2;
            if (s) begin
                sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
                sb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            qq = sa / sb;
            rr = sa % sb;
            q = qq[W-1:0];
            r = rr[W-1:0];
        end
    endtask

    // Called at a negedge in IDLE. Issues one operation and checks every
    // cycle up to and including the first IDLE cycle after done.
    // extra_k: cycle in which a spurious start is pulsed (0 = none).
    // poke_done: also pulse start during the done cycle.
    task automatic run_op(input string tag, input bit s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int extra_k, input bit poke_done);
        logic [W-1:0] eq, er;
        bit edz, eov;
        int lat;
        ref_model(s, a, b, eq, er, edz, eov, lat);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start     = (k == extra_k) || (poke_done && k == lat);
            signed_op = 1'($urandom);
            dividend  = W'($urandom);
            divisor   = W'($urandom);
            chk({tag, " busy"}, 64'(busy), 64'd1);
            chk({tag, " done"}, 64'(done), 64'(k == lat));
            if (k < lat) begin
                chk({tag, " q held"}, 64'(quotient), 64'(q_prev));
                chk({tag, " r held"}, 64'(remainder), 64'(r_prev));
            end else begin
                chk({tag, " quotient"}, 64'(quotient), 64'(eq));
                chk({tag, " remainder"}, 64'(remainder), 64'(er));
                chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
                chk({tag, " ovfl"}, 64'(ovfl), 64'(eov));
            end
        end
        q_prev = eq;
        r_prev = er;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " idle busy"}, 64'(busy), 64'd0);
        chk({tag, " idle done"}, 64'(done), 64'd0);
        chk({tag, " idle q"}, 64'(quotient), 64'(eq));
        $display("op %s: s=%0d %h / %h -> q=%h r=%h dz=%0d ov=%0d", tag, s, a, b,
                 quotient, remainder, div_by_zero, ovfl);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit rs;
        int sel, ek;

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset q", 64'(quotient), 64'd0);
        chk("reset r", 64'(remainder), 64'd0);
        chk("reset dz", 64'(div_by_zero), 64'd0);
        chk("reset ovfl", 64'(ovfl), 64'd0);
        rst = 1'b0;

        run_op("u100/7", 1'b0, 16'h0064, 16'h0007, 0, 1'b0);
        run_op("s-7/2", 1'b1, 16'hFFF9, 16'h0002, 0, 1'b0);
        run_op("s7/-2", 1'b1, 16'h0007, 16'hFFFE, 0, 1'b0);
        run_op("s/0", 1'b1, 16'h1234, 16'h0000, 0, 1'b0);
        run_op("u/0", 1'b0, 16'h1234, 16'h0000, 0, 1'b0);
        run_op("clear dz", 1'b0, 16'h0009, 16'h0003, 0, 1'b0);
        run_op("s min/-1", 1'b1, 16'h8000, 16'hFFFF, 0, 1'b0);
        run_op("u 8000/FFFF", 1'b0, 16'h8000, 16'hFFFF, 0, 1'b0);
        run_op("u FFFF/8001", 1'b0, 16'hFFFF, 16'h8001, 5, 1'b0);
        run_op("start in done", 1'b0, 16'h4321, 16'h0010, 0, 1'b1);
        run_op("div by 1", 1'b0, 16'hBEEF, 16'h0001, 0, 1'b0);
        run_op("s div by 1", 1'b1, 16'hBEEF, 16'h0001, 0, 1'b0);
        run_op("small/large", 1'b0, 16'h0005, 16'h0100, 0, 1'b0);
        run_op("s min/3", 1'b1, 16'h8000, 16'h0003, 0, 1'b0);

        // Reset in the middle of CALC discards the operation
        signed_op = 1'b0; dividend = 16'hABCD; divisor = 16'h0123; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("midrst busy", 64'(busy), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy0", 64'(busy), 64'd0);
        chk("midrst done0", 64'(done), 64'd0);
        chk("midrst q0", 64'(quotient), 64'd0);
        chk("midrst r0", 64'(remainder), 64'd0);
        q_prev = '0;
        r_prev = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("midrst no done", 64'(done), 64'd0);
        end
        $display("op midrst: reset during CALC, no done observed");
        run_op("after rst", 1'b0, 16'h0064, 16'h0007, 0, 1'b0);

        // Randomized operations, back to back
        for (int i = 0; i < 40; i++) begin
            rs  = 1'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
            else if (sel == 2) rb = W'($urandom_range(1, 15));
            else if (sel == 3) begin ra = W'($urandom_range(0, 255)); rb = ra + W'($urandom_range(1, 100)); end
            ek = (sel > 6) ? $urandom_range(1, 17) : 0;
            if (rb == 0 || (rs && ra == 16'h8000 && rb == 16'hFFFF)) ek = 0;
            run_op("rand", rs, ra, rb, ek, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
